// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, sequencer phases and
// the control-strobe bundle. Used by the controller and the ALU decode.
package cpu_pkg;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic ld_ac;
        logic ld_pc;
        logic inc_pc;
        logic data_e;
        logic halt;
    } strobes_t;

    // Instructions that read an operand from memory and write the accumulator.
    function automatic logic isAluOp(input opcode_t op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_phase_counter.sv
// Three-bit instruction phase counter: advances on ena, wraps 7 -> 0,
// synchronous clear has priority over ena.
module ctrl_phase_counter (
    input  logic       clk,
    input  logic       clear,
    input  logic       ena,
    output logic [2:0] phase
);

    always_ff @(posedge clk) begin
        if (clear) begin
            phase <= 3'd0;
        end else if (ena) begin
            phase <= phase + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer producing the datapath control strobes.
// Optional feature macro: CTRL_HALT_RESUME_EN adds a resume input that releases HALTED.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef CTRL_HALT_RESUME_EN
    input  logic       resume,
`endif
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt
);

    logic [2:0] phase_count;
    phase_t     phase;
    opcode_t    op;
    logic       halted;
    logic       halt_entry;
    logic       release_halt;
    strobes_t   strobes;

    assign phase = phase_t'(phase_count);
    assign op    = opcode_t'(opcode);

    assign halt_entry = ena && !halted && (phase == OP_ADDR) && (op == OP_HLT);

`ifdef CTRL_HALT_RESUME_EN
    assign release_halt = halted && resume;
`else
    assign release_halt = 1'b0;
`endif

    // The counter takes the HLT edge into OP_FETCH, then freezes while halted.
    ctrl_phase_counter u_phase (
        .clk   (clk),
        .clear (rst || release_halt),
        .ena   (ena && !halted),
        .phase (phase_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (release_halt) begin
            halted <= 1'b0;
        end else if (halt_entry) begin
            halted <= 1'b1;
        end
    end

    always_comb begin
        strobes = '0;
        if (halted) begin
            strobes.halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: begin
                    strobes.sel = 1'b1;
                end
                INST_FETCH: begin
                    strobes.sel = 1'b1;
                    strobes.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    strobes.sel   = 1'b1;
                    strobes.rd    = 1'b1;
                    strobes.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    strobes.inc_pc = 1'b1;
                    strobes.halt   = (op == OP_HLT);
                end
                OP_FETCH: begin
                    strobes.rd = isAluOp(op);
                end
                ALU_OP: begin
                    // zero only matters here, where SKZ decides whether to skip.
                    strobes.rd     = isAluOp(op);
                    strobes.inc_pc = (op == OP_SKZ) && zero;
                    strobes.ld_pc  = (op == OP_JMP);
                    strobes.data_e = (op == OP_STO);
                end
                STORE: begin
                    strobes.rd     = isAluOp(op);
                    strobes.ld_ac  = isAluOp(op);
                    strobes.ld_pc  = (op == OP_JMP);
                    strobes.wr     = (op == OP_STO);
                    strobes.data_e = (op == OP_STO);
                end
                default: begin
                    strobes = '0;
                end
            endcase
        end
    end

    assign sel    = strobes.sel;
    assign rd     = strobes.rd;
    assign wr     = strobes.wr;
    assign ld_ir  = strobes.ld_ir;
    assign ld_ac  = strobes.ld_ac;
    assign ld_pc  = strobes.ld_pc;
    assign inc_pc = strobes.inc_pc;
    assign data_e = strobes.data_e;
    assign halt   = strobes.halt;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: fixed vector table, directed
// multi-cycle sequences and randomized cycles against a behavioural model.
module tb_cpu_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       resume;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [8:0] actual;

`ifdef CTRL_HALT_RESUME_EN
    localparam bit RESUME_EN = 1'b1;
`else
    localparam bit RESUME_EN = 1'b0;
`endif

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, STO = 3'd6, JMP = 3'd7;
    localparam int M_MODEL = 0, M_FIXED = 1, M_NONE = 2;

    always #5 clk = ~clk;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .opcode (opcode),
        .zero   (zero),
`ifdef CTRL_HALT_RESUME_EN
        .resume (resume),
`endif
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt)
    );

    assign actual = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

    int checks = 0;
    int passed = 0;
    int m_phase = 0;
    bit m_halted = 1'b0;

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] op;
        logic       z;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Strobe bits ordered {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}.
    function automatic logic [8:0] expected_out(input int ph, input bit hl,
                                                input logic [2:0] op, input logic z);
        logic aluop, s, r, w, ir, ac, pc, inc, de, h;
        aluop = (op >= 3'd2) && (op <= 3'd5);
        if (hl) return 9'b000000001;
        s   = (ph < 4);
        r   = (ph >= 1 && ph <= 3) || (aluop && ph >= 5);
        w   = (op == STO) && (ph == 7);
        ir  = (ph == 2) || (ph == 3);
        ac  = aluop && (ph == 7);
        pc  = (op == JMP) && (ph >= 6);
        inc = (ph == 4) || ((ph == 6) && (op == SKZ) && z);
        de  = (op == STO) && (ph >= 6);
        h   = (ph == 4) && (op == HLT);
        return {s, r, w, ir, ac, pc, inc, de, h};
    endfunction

    task automatic modelEdge();
        if (rst) begin
            m_phase  = 0;
            m_halted = 1'b0;
        end else if (m_halted) begin
            if (RESUME_EN && resume) begin
                m_halted = 1'b0;
                m_phase  = 0;
            end
        end else if (ena) begin
            if (m_phase == 4 && opcode == HLT) m_halted = 1'b1;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [2:0] op,
                                 input logic z, input logic res);
        rst    = r;
        ena    = e;
        opcode = op;
        zero   = z;
        resume = res;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] exp);
        checks++;
        if (actual === exp) passed++;
        else $display("[TB] FAIL %s: got %b expected %b (model phase %0d halted %0d)",
                      name, actual, exp, m_phase, m_halted);
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Outputs while rst is held mid-instruction are not pinned down, so skip those.
    task automatic cycle(input logic r, input logic e, input logic [2:0] op, input logic z,
                         input logic res, input string name, input int mode,
                         input logic [8:0] fixed);
        applyStimulus(r, e, op, z, res);
        #2;
        if (mode == M_FIXED) checkOutput(name, fixed);
        else if (mode == M_MODEL && !(r && (m_phase != 0 || m_halted)))
            checkOutput(name, expected_out(m_phase, m_halted, op, z));
        tick();
    endtask

    task automatic addVec(input logic r, input logic e, input logic [2:0] op,
                          input logic z, input logic [8:0] exp);
        vec_t v;
        v.r = r; v.e = e; v.op = op; v.z = z; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic addFetch(input logic [2:0] op, input logic z);
        addVec(0, 1, op, z, 9'b100000000);
        addVec(0, 1, op, z, 9'b110000000);
        addVec(0, 1, op, z, 9'b110100000);
        addVec(0, 1, op, z, 9'b110100000);
        addVec(0, 1, op, z, 9'b000000100);
    endtask

    initial begin
        logic [2:0] cur_op;
        logic       r, e, z, res;

        applyStimulus(1, 0, ADD, 0, 0);
        tick();
        tick();

        addVec(1, 1, ADD, 0, 9'b100000000);
        addFetch(ADD, 0);
        addVec(0, 1, ADD, 0, 9'b010000000);
        addVec(0, 1, ADD, 0, 9'b010000000);
        addVec(0, 1, ADD, 0, 9'b010010000);
        addFetch(STO, 0);
        addVec(0, 1, STO, 0, 9'b000000000);
        addVec(0, 1, STO, 0, 9'b000000010);
        addVec(0, 1, STO, 0, 9'b001000010);
        addFetch(JMP, 1);
        addVec(0, 1, JMP, 1, 9'b000000000);
        addVec(0, 1, JMP, 1, 9'b000001000);
        addVec(0, 1, JMP, 1, 9'b000001000);
        addFetch(SKZ, 1);
        addVec(0, 1, SKZ, 1, 9'b000000000);
        addVec(0, 1, SKZ, 1, 9'b000000100);
        addVec(0, 1, SKZ, 1, 9'b000000000);
        addFetch(SKZ, 0);
        addVec(0, 1, SKZ, 0, 9'b000000000);
        addVec(0, 1, SKZ, 0, 9'b000000000);
        addVec(0, 1, SKZ, 0, 9'b000000000);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].e, vecs[i].op, vecs[i].z, 0);
            #2;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end

        // SKZ with zero raised only in OP_FETCH must not skip.
        for (int p = 0; p < 5; p++) cycle(0, 1, SKZ, 0, 0, "skz_fetch", M_MODEL, '0);
        cycle(0, 1, SKZ, 1, 0, "skz_zero_p5", M_MODEL, '0);
        cycle(0, 1, SKZ, 0, 0, "skz_no_skip_p6", M_FIXED, 9'b000000000);
        cycle(0, 1, SKZ, 0, 0, "skz_p7", M_MODEL, '0);

        // HLT: halt in OP_ADDR, then a sticky halt that ignores ena.
        for (int p = 0; p < 4; p++) cycle(0, 1, HLT, 0, 0, "hlt_fetch", M_MODEL, '0);
        cycle(0, 1, HLT, 0, 0, "hlt_op_addr", M_FIXED, 9'b000000101);
        for (int c = 0; c < 20; c++)
            cycle(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 0, "halted_hold", M_FIXED, 9'b000000001);
        cycle(1, 1, ADD, 0, 0, "halted_rst", M_NONE, '0);
        cycle(0, 1, ADD, 0, 0, "after_halt_rst", M_FIXED, 9'b100000000);

        if (RESUME_EN) begin
            for (int p = 1; p < 5; p++) cycle(0, 1, HLT, 0, 0, "hlt2", M_MODEL, '0);
            cycle(0, 1, HLT, 0, 0, "halted2", M_FIXED, 9'b000000001);
            cycle(0, 0, HLT, 0, 1, "resume_pulse", M_FIXED, 9'b000000001);
            cycle(0, 1, ADD, 0, 0, "after_resume", M_FIXED, 9'b100000000);
            for (int p = 1; p < 8; p++) cycle(0, 1, ADD, 0, 0, "post_resume", M_MODEL, '0);
        end

        // Stall three cycles in INST_LOAD; instruction then takes 11 cycles total.
        cycle(1, 1, ADD, 0, 0, "stall_rst", M_NONE, '0);
        cycle(0, 1, ADD, 0, 0, "stall_p0", M_MODEL, '0);
        cycle(0, 1, ADD, 0, 0, "stall_p1", M_MODEL, '0);
        for (int c = 0; c < 3; c++) cycle(0, 0, ADD, 0, 0, "stall_hold", M_FIXED, 9'b110100000);
        for (int c = 0; c < 6; c++) cycle(0, 1, ADD, 0, 0, "stall_finish", M_MODEL, '0);
        cycle(0, 1, ADD, 0, 0, "stall_wrap", M_FIXED, 9'b100000000);

        // Reset during ALU_OP of a store drops the pending write.
        for (int p = 1; p < 6; p++) cycle(0, 1, STO, 0, 0, "sto_run", M_MODEL, '0);
        cycle(1, 1, STO, 0, 0, "sto_rst", M_NONE, '0);
        cycle(0, 1, STO, 0, 0, "sto_after_rst", M_FIXED, 9'b100000000);

        cur_op = ADD;
        for (int c = 0; c < 1500; c++) begin
            if (m_phase == 2 && !m_halted) cur_op = 3'($urandom_range(0, 7));
            r   = ($urandom_range(0, 39) == 0);
            e   = ($urandom_range(0, 3) != 0);
            z   = 1'($urandom_range(0, 1));
            res = ($urandom_range(0, 15) == 0);
            cycle(r, e, cur_op, z, res, "random", M_MODEL, '0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
